// File: rtl/encrypt_iter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : encrypt_iter_pkg
// Brief    : Shared widths, mode and FSM encodings, and GF(2^8) helpers for
//            the iterative AES-style block encryptor.
// Revision : 1.0 - initial release
// ============================================================================
package encrypt_iter_pkg;

    localparam int c_N_B = 128;     // block width in bits
    localparam int c_N_K = 128;     // key width in bits
    localparam int c_N_R = 10;      // default round count

    localparam logic c_MODE_ECB = 1'b0;
    localparam logic c_MODE_CBC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (a^254, which also maps 0 to 0) followed
    // by the affine transform. Computed rather than tabulated.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);   // a^127
        r = gf_mul(r, r);                                           // a^254
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Round constant for key-schedule step n (1..15)
    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] v;
        case (n)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            4'd11:   v = 8'h6c;
            4'd12:   v = 8'hd8;
            4'd13:   v = 8'hab;
            4'd14:   v = 8'h4d;
            4'd15:   v = 8'h9a;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage : encrypt_iter_pkg
`default_nettype wire

// File: rtl/encrypt_iter_round_step.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_iter_round_step
// Brief    : One combinational cipher round (SubBytes, ShiftRows, MixColumns
//            unless final, AddRoundKey) together with the key-schedule step
//            that produces the round key it uses.
// Revision : 1.0 - initial release
// ============================================================================
module encrypt_iter_round_step
    import encrypt_iter_pkg::*;
#(
    parameter int N_B = c_N_B,
    parameter int N_K = c_N_K
) (
    input  logic [N_B-1:0] i_state,
    input  logic [N_K-1:0] i_key,
    input  logic [3:0]     i_round,
    input  logic           i_final,
    output logic [N_B-1:0] o_state,
    output logic [N_K-1:0] o_key
);

    // Byte 0 is the most significant byte; state is column-major (byte 4*col+row)
    logic [0:15][7:0] w_in;
    logic [0:15][7:0] w_sb;
    logic [0:15][7:0] w_sr;
    logic [0:15][7:0] w_mc;
    logic [0:3][31:0] w_kw;
    logic [0:3][31:0] w_kn;
    logic [31:0]      w_temp;

    assign w_in = i_state;
    assign w_kw = i_key;

    // Byte substitution, row rotation and column mixing of the current state
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int i = 0; i < 16; i++) begin
            w_sb[i] = sbox(w_in[i]);
        end
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                w_sr[4*col+row] = w_sb[4*((col+row)%4)+row];
            end
        end
        for (int col = 0; col < 4; col++) begin
            w_mc[4*col+0] = xtime(w_sr[4*col+0]) ^ xtime(w_sr[4*col+1]) ^ w_sr[4*col+1]
                          ^ w_sr[4*col+2] ^ w_sr[4*col+3];
            w_mc[4*col+1] = w_sr[4*col+0] ^ xtime(w_sr[4*col+1]) ^ xtime(w_sr[4*col+2])
                          ^ w_sr[4*col+2] ^ w_sr[4*col+3];
            w_mc[4*col+2] = w_sr[4*col+0] ^ w_sr[4*col+1] ^ xtime(w_sr[4*col+2])
                          ^ xtime(w_sr[4*col+3]) ^ w_sr[4*col+3];
            w_mc[4*col+3] = xtime(w_sr[4*col+0]) ^ w_sr[4*col+0] ^ w_sr[4*col+1]
                          ^ w_sr[4*col+2] ^ xtime(w_sr[4*col+3]);
        end
    end

    // Key schedule: RotWord + SubWord of the last word, XOR round constant
    assign w_temp = {sbox(w_kw[3][23:16]), sbox(w_kw[3][15:8]),
                     sbox(w_kw[3][7:0]),   sbox(w_kw[3][31:24])}
                  ^ {rcon(i_round), 24'h000000};
    assign w_kn[0] = w_kw[0] ^ w_temp;
    assign w_kn[1] = w_kw[1] ^ w_kn[0];
    assign w_kn[2] = w_kw[2] ^ w_kn[1];
    assign w_kn[3] = w_kw[3] ^ w_kn[2];

    assign o_key   = w_kn;
    assign o_state = (i_final ? w_sr : w_mc) ^ w_kn;

endmodule : encrypt_iter_round_step
`default_nettype wire

// File: rtl/encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_iter
// Brief    : Iterative block encryptor, one round per clock, with ECB/CBC
//            chaining and valid/ready handshakes on plaintext and ciphertext.
// Revision : 1.0 - initial release
// ============================================================================
module encrypt_iter
    import encrypt_iter_pkg::*;
#(
    parameter int N_B = c_N_B,
    parameter int N_K = c_N_K,
    parameter int N_R = c_N_R
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] m,
    input  logic           m_valid,
    output logic           m_ready,
    input  logic           mode,
    input  logic [N_B-1:0] iv,
    input  logic           iv_load,
    output logic [N_B-1:0] c,
    output logic           c_valid,
    input  logic           c_ready,
    output logic           busy
);

    localparam logic [3:0] c_LAST = 4'(N_R);

    fsm_t           r_fsm;
    fsm_t           w_fsm_next;
    logic [3:0]     r_cnt;
    logic [N_B-1:0] r_state;
    logic [N_K-1:0] r_key;
    logic [N_B-1:0] r_chain;
    logic [N_B-1:0] r_c;
    logic           r_cvalid;
    logic           r_mode;

    logic           w_accept;
    logic           w_last;
    logic           w_chain_we;
    logic [N_B-1:0] w_chain_d;
    logic [N_B-1:0] w_x;
    logic [N_B-1:0] w_rs_state;
    logic [N_K-1:0] w_rs_key;

    assign w_last = (r_cnt == c_LAST);

    encrypt_iter_round_step #(
        .N_B (N_B),
        .N_K (N_K)
    ) u_round_step (
        .i_state (r_state),
        .i_key   (r_key),
        .i_round (r_cnt),
        .i_final (w_last),
        .o_state (w_rs_state),
        .o_key   (w_rs_key)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fsm <= ST_IDLE;
        else      r_fsm <= w_fsm_next;
    end

    // Next state, plaintext-ready, and the chain value seen by a block accepted this cycle
    always_comb begin
        w_fsm_next = r_fsm;
        m_ready    = 1'b0;
        w_chain_we = 1'b0;
        w_chain_d  = r_chain;
        case (r_fsm)
            ST_IDLE: begin
                m_ready = 1'b1;
                if (iv_load) begin
                    w_chain_we = 1'b1;
                    w_chain_d  = iv;
                end
                if (m_valid) w_fsm_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_fsm_next = ST_DONE;
            end
            ST_DONE: begin
                if (c_ready) begin
                    m_ready = 1'b1;
                    if (r_mode == c_MODE_CBC) begin
                        w_chain_we = 1'b1;
                        w_chain_d  = r_c;
                    end
                    w_fsm_next = m_valid ? ST_RUN : ST_IDLE;
                end
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    assign w_accept = m_valid & m_ready;
    assign w_x      = (mode == c_MODE_CBC) ? w_chain_d : '0;
    assign busy     = (r_fsm != ST_IDLE);
    assign c        = r_c;
    assign c_valid  = r_cvalid;

    // Datapath: load on accept, one round per RUN cycle, capture result at the final round
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 4'd0;
            r_state  <= '0;
            r_key    <= '0;
            r_chain  <= '0;
            r_c      <= '0;
            r_cvalid <= 1'b0;
            r_mode   <= c_MODE_ECB;
        end else begin
            if (w_chain_we) r_chain <= w_chain_d;

            if (w_accept) begin
                r_key   <= k;
                r_state <= m ^ w_x ^ k;
                r_cnt   <= 4'd1;
                r_mode  <= mode;
            end else if (r_fsm == ST_RUN) begin
                r_state <= w_rs_state;
                r_key   <= w_rs_key;
                r_cnt   <= r_cnt + 4'd1;
            end

            if (r_fsm == ST_RUN && w_last) begin
                r_c      <= w_rs_state;
                r_cvalid <= 1'b1;
            end else if (r_fsm == ST_DONE && c_ready) begin
                r_cvalid <= 1'b0;
            end
        end
    end

endmodule : encrypt_iter
`default_nettype wire

// File: tb/tb_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_encrypt_iter
// Brief    : Self-checking bench for encrypt_iter: transaction-level cipher
//            model, per-cycle output comparison, directed known-answer cases
//            and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encrypt_iter;

    localparam int NR = 10;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] M1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] M2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] k = '0, m = '0, iv = '0;
    logic         m_valid = 1'b0, mode = 1'b0, iv_load = 1'b0, c_ready = 1'b0;
    logic         m_ready, c_valid, busy;
    logic [127:0] c;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cv_count = 0;
    int           hs_t[$];
    logic [127:0] hs_c[$];

    logic [7:0] tb_sbox [256];

    // transaction-level model state
    int           mdl_timer = 0;
    logic         mdl_cv    = 1'b0;
    logic         mdl_mode  = 1'b0;
    logic [127:0] mdl_c     = '0;
    logic [127:0] mdl_chain = '0;
    logic [127:0] mdl_pend  = '0;
    logic         mdl_rdy, mdl_idle;

    encrypt_iter #(.N_B(128), .N_K(128), .N_R(NR)) dut (
        .clk     (clk),
        .rst     (rst),
        .k       (k),
        .m       (m),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .mode    (mode),
        .iv      (iv),
        .iv_load (iv_load),
        .c       (c),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // polynomial multiply in GF(2^8) on plain integers
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p, aa, bb;
        p = 0; aa = int'(a); bb = int'(b);
        while (bb != 0) begin
            if ((bb & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 256) != 0) aa = aa ^ 'h11b;
            bb = bb >> 1;
        end
        return p[7:0];
    endfunction

    // reference block cipher on a 4x4 byte matrix s[row][col]
    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   w [4][4];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [127:0] out;
        rc = 8'h01;
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++) begin
                w[col][row] = key[127-8*(4*col+row) -: 8];
                s[row][col] = pt[127-8*(4*col+row) -: 8] ^ w[col][row];
            end
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int row = 0; row < 4; row++) tmp[row] = tb_sbox[w[3][(row+1)%4]];
            tmp[0] = tmp[0] ^ rc;
            for (int row = 0; row < 4; row++) w[0][row] = w[0][row] ^ tmp[row];
            for (int col = 1; col < 4; col++)
                for (int row = 0; row < 4; row++) w[col][row] = w[col][row] ^ w[col-1][row];
            rc = gmul(rc, 8'h02);
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++) t[row][col] = tb_sbox[s[row][(col+row)%4]];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++) begin
                    if (rnd != NR)
                        s[row][col] = gmul(t[row][col], 8'h02) ^ gmul(t[(row+1)%4][col], 8'h03)
                                    ^ t[(row+2)%4][col] ^ t[(row+3)%4][col];
                    else
                        s[row][col] = t[row][col];
                    s[row][col] = s[row][col] ^ w[col][row];
                end
        end
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++) out[127-8*(4*col+row) -: 8] = s[row][col];
        return out;
    endfunction

    // model: one edge per iteration, asynchronous clear on reset
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mdl_timer = 0; mdl_cv = 1'b0; mdl_mode = 1'b0;
            mdl_c = '0; mdl_chain = '0; mdl_pend = '0;
        end else begin
            mdl_idle = (mdl_timer == 0) && !mdl_cv;
            mdl_rdy  = mdl_idle || (mdl_cv && c_ready);
            if (mdl_cv && c_ready) begin
                if (mdl_mode) mdl_chain = mdl_c;
                mdl_cv = 1'b0;
            end
            if (mdl_idle && iv_load) mdl_chain = iv;
            if (m_valid && mdl_rdy) begin
                mdl_pend  = aes_enc(k, m ^ (mode ? mdl_chain : 128'h0));
                mdl_mode  = mode;
                mdl_timer = NR;
            end else if (mdl_timer > 0) begin
                mdl_timer--;
                if (mdl_timer == 0) begin
                    mdl_c  = mdl_pend;
                    mdl_cv = 1'b1;
                end
            end
        end
    end

    // compare DUT outputs against the model every cycle, mid-period
    initial forever begin
        @(negedge clk);
        cyc++;
        check("c", c, mdl_c);
        check("c_valid", 128'(c_valid), 128'(mdl_cv));
        check("busy", 128'(busy), 128'((mdl_timer > 0) || mdl_cv));
        check("m_ready", 128'(m_ready), 128'(((mdl_timer == 0) && !mdl_cv) || (mdl_cv && c_ready)));
        if (c_valid) cv_count++;
        if (c_valid && c_ready) begin
            hs_t.push_back(cyc);
            hs_c.push_back(c);
        end
    end

    task automatic send(input logic [127:0] kk, input logic [127:0] mm, input logic md);
        k = kk; m = mm; mode = md; m_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m_ready) break;
            if (n == 199) check("send_timeout", 128'(m_ready), 128'(1));
        end
        @(posedge clk); #1;
        m_valid = 1'b0;
    endtask

    task automatic wait_cv(output int n);
        n = 0;
        while (!c_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int           lat;
        int           cv_before;
        logic [127:0] c_cbc2;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            tb_sbox[x] = s ^ 8'h63;
        end
        rst = 1'b0;

        // model pinned to known answers
        check("model_kat1", aes_enc(K1, M1), C1);
        check("model_kat2", aes_enc(K2, M2), C2);

        repeat (3) @(posedge clk); #1;
        check("rst_c", c, 128'h0);
        check("rst_c_valid", 128'(c_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_m_ready", 128'(m_ready), 128'h1);

        // ECB known answer with latency
        c_ready = 1'b0;
        send(K1, M1, 1'b0);
        wait_cv(lat);
        check("ecb1_latency", 128'(lat), 128'(NR));
        check("ecb1_c", c, C1);
        c_ready = 1'b1; @(posedge clk); #1; c_ready = 1'b0;

        // ECB known answer held under back-pressure
        send(K2, M2, 1'b0);
        wait_cv(lat);
        repeat (20) @(posedge clk); #1;
        check("ecb2_c_held", c, C2);
        check("ecb2_c_valid_held", 128'(c_valid), 128'h1);
        check("ecb2_m_ready_stall", 128'(m_ready), 128'h0);
        c_ready = 1'b1; @(posedge clk); #1; c_ready = 1'b0;

        // CBC, zero IV, two blocks back to back
        iv = '0; iv_load = 1'b1; @(posedge clk); #1; iv_load = 1'b0;
        hs_t.delete(); hs_c.delete();
        c_ready = 1'b1;
        send(K1, M1, 1'b1);
        send(K1, M1, 1'b1);
        wait_cv(lat);
        @(posedge clk); #1;
        c_cbc2 = aes_enc(K1, M1 ^ C1);
        check("cbc_blocks", 128'(hs_c.size()), 128'h2);
        if (hs_c.size() >= 2) begin
            check("cbc_c1", hs_c[0], C1);
            check("cbc_c2", hs_c[1], c_cbc2);
            check("cbc_spacing", 128'(hs_t[1] - hs_t[0]), 128'(NR + 1));
        end

        // iv_load during RUN is ignored; chain stays at the previous ciphertext
        iv = {128{1'b1}};
        send(K1, M1, 1'b1);
        iv_load = 1'b1; repeat (2) @(posedge clk); #1; iv_load = 1'b0;
        wait_cv(lat);
        check("cbc_iv_ignored", c, aes_enc(K1, M1 ^ c_cbc2));
        @(posedge clk); #1;

        // reset in the middle of a block
        c_ready = 1'b0;
        send(K1, M1, 1'b0);
        repeat (4) @(posedge clk); #1;
        rst = 1'b0; #1;
        check("midrst_c", c, 128'h0);
        check("midrst_c_valid", 128'(c_valid), 128'h0);
        check("midrst_busy", 128'(busy), 128'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_m_ready", 128'(m_ready), 128'h1);
        cv_before = cv_count;
        repeat (15) @(posedge clk); #1;
        check("midrst_no_stray", 128'(cv_count), 128'(cv_before));
        c_ready = 1'b1;
        send(K1, M1, 1'b0);
        wait_cv(lat);
        check("midrst_next_c", c, C1);
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            m_valid = ($urandom_range(0, 3) != 0);
            c_ready = ($urandom_range(0, 2) != 0);
            iv_load = ($urandom_range(0, 7) == 0);
            mode    = 1'($urandom_range(0, 1));
            k  = {$urandom(), $urandom(), $urandom(), $urandom()};
            m  = {$urandom(), $urandom(), $urandom(), $urandom()};
            iv = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
        m_valid = 1'b0; iv_load = 1'b0; c_ready = 1'b1;
        repeat (15) @(posedge clk); #1;
        check("drain_idle", 128'(busy), 128'h0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_encrypt_iter
`default_nettype wire

// File: doc/encrypt_iter.md
ENCRYPT_ITER -- requirements
Module: encrypt_iter

Interface
REQ-001 Parameter N_B, default `N_B (128): block width in bits.
REQ-002 Parameter N_K, default `N_K (128): key width in bits.
REQ-003 Parameter N_R, default 10: round count, legal range 1..15.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 k  input  N_K  cipher key, sampled at accept.
REQ-007 m  input  N_B  plaintext block, sampled at accept.
REQ-008 m_valid  input  1  plaintext offered.
REQ-009 m_ready  output  1  block can accept plaintext.
REQ-010 mode  input  1  0 = ECB, 1 = CBC; sampled at accept.
REQ-011 iv  input  N_B  CBC initial vector.
REQ-012 iv_load  input  1  load iv into chain register.
REQ-013 c  output  N_B  ciphertext block.
REQ-014 c_valid  output  1  ciphertext available.
REQ-015 c_ready  input  1  consumer takes ciphertext.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: m_ready=1; on m_valid, latch key register ← k, state ← m ^ x ^ k, where x = chain if mode=1 else 0; clear round counter to 1; go to RUN.
REQ-019 RUN: each cycle apply one round_step to state and round key; final-round flag set when counter = N_R; counter increments.
REQ-020 RUN → DONE on the cycle the final round completes; c ← state and c_valid=1 in DONE.
REQ-021 Latency: accept at edge t → c_valid high after edge t+N_R.
REQ-022 DONE: c and c_valid hold stable until c_ready=1; no change while c_ready=0.
REQ-023 DONE with c_ready=1: if the latched mode=1, chain ← c; then go to IDLE, c_valid drops next cycle.
REQ-024 DONE with c_ready=1 and m_valid=1: m_ready=1; the new block is accepted in the same cycle and uses the updated chain (= c) for CBC; next state RUN (back-to-back, N_R+1 cycles per block).
REQ-025 m_ready=0 in RUN, and in DONE when c_ready=0.
REQ-026 iv_load honoured only in IDLE; ignored in RUN/DONE.
REQ-027 iv_load and an accepted m_valid in the same IDLE cycle: the block uses iv as x; chain ← iv.
REQ-028 Round counter width 4 bits; no wrap reachable for legal N_R.
REQ-029 k, m, mode changes after accept have no effect on the block in flight.

Reset
REQ-030 rst=0 forces, asynchronously: FSM=IDLE, c=0, c_valid=0, busy=0, chain=0, counter=0, state and key registers=0.
REQ-031 m_ready=1 from the first cycle after rst releases.
REQ-032 Reset mid-RUN or mid-DONE discards the block; no c_valid pulse after release.

Structure
REQ-033 params.h holds N_B, N_K, default N_R, mode encodings (ECB=0, CBC=1) and FSM state encodings.
REQ-034 One sub-module, round_step: combinational single round (SubBytes, ShiftRows, MixColumns skipped on final flag, AddRoundKey) plus one key-schedule step, with round constant selected by counter.
REQ-035 encrypt_iter contains only FSM, counter, state/key/chain/output registers, and handshake logic.

Verification
REQ-036 ECB, k=000102030405060708090a0b0c0d0e0f, m=00112233445566778899aabbccddeeff → c=69c4e0d86a7b0430d8cdb78070b4c55a, c_valid exactly 10 cycles after accept.
REQ-037 ECB, k=2b7e151628aed2a6abf7158809cf4f3c, m=3243f6a8885a308d313198a2e0370734 → c=3925841d02dc09fbdc118597196a0b32; hold c_ready=0 20 cycles → c stable, m_ready=0.
REQ-038 CBC, iv_load with iv=0, then two back-to-back blocks (vector REQ-036 then same m) → first c equals REQ-036 result; second c equals ECB(m ^ 69c4…c55a) from the model; spacing 11 cycles.
REQ-039 CBC with iv=ffff…ff, iv_load pulsed during RUN → ignored; ciphertext uses previous chain.
REQ-040 rst=0 asserted at round 5 of a block → outputs zero immediately; after release m_ready=1, no stray c_valid, next block REQ-036 correct.
